// File: rtl/mem_port_ctl_pkg.sv
// rtl/mem_port_ctl_pkg.sv - shared encodings and fault rule for the memory port controller
package mem_port_ctl_pkg;

   localparam logic [1:0] MM_WR_N  = 2'd0;
   localparam logic [1:0] MM_WR_B  = 2'd1;
   localparam logic [1:0] MM_WR_HW = 2'd2;
   localparam logic [1:0] MM_WR_W  = 2'd3;

   localparam logic [2:0] FT_LB  = 3'b000;
   localparam logic [2:0] FT_LH  = 3'b001;
   localparam logic [2:0] FT_LW  = 3'b010;
   localparam logic [2:0] FT_LBU = 3'b100;
   localparam logic [2:0] FT_LHU = 3'b101;

   localparam logic [1:0] MPC_IDLE = 2'd0;
   localparam logic [1:0] MPC_BUSY = 2'd1;
   localparam logic [1:0] MPC_RESP = 2'd2;

   // A data access that must never reach the bus: misaligned size or unknown load funct3.
   function automatic logic data_fault(input logic [1:0] wr, input logic [2:0] trim,
                                       input logic [1:0] a);
      logic f;
      f = 1'b0;
      if (wr == MM_WR_N) begin
         case (trim)
            FT_LB, FT_LBU: f = 1'b0;
            FT_LH, FT_LHU: f = a[0];
            FT_LW:         f = (a != 2'b00);
            default:       f = 1'b1;
         endcase
      end else if (wr == MM_WR_HW) begin
         f = a[0];
      end else if (wr == MM_WR_W) begin
         f = (a != 2'b00);
      end
      return f;
   endfunction

endpackage

// File: rtl/mem_port_ctl_load_align.sv
// rtl/mem_port_ctl_load_align.sv - selects and extends a byte/half/word from a read word
module load_align
   import mem_port_ctl_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[{addr_lo, 3'b000} +: 8];
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];
      case (funct3)
         FT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         FT_LH:   result = {{16{half_sel[15]}}, half_sel};
         FT_LW:   result = word;
         FT_LBU:  result = {24'd0, byte_sel};
         FT_LHU:  result = {16'd0, half_sel};
         default: result = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_port_ctl.sv
// rtl/mem_port_ctl.sv - arbitrates fetch and load/store traffic onto one memory port
module mem_port_ctl
   import mem_port_ctl_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        IF_REQ,
   input  logic [31:0] IF_ADDR,
   output logic [31:0] IF_RDATA,
   output logic        IF_VALID,
   input  logic        D_REQ,
   input  logic [1:0]  D_WR,
   input  logic [2:0]  D_TRIM,
   input  logic [31:0] D_ADDR,
   input  logic [31:0] D_WDATA,
   output logic [31:0] D_RDATA,
   output logic        D_VALID,
   output logic        ERR,
   output logic        STALL,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   output logic [3:0]  MEM_BE,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] MEM_WDATA,
   input  logic        MEM_ACK,
   input  logic [31:0] MEM_RDATA
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]  state;
   logic [7:0]  tmo_cnt;
   logic        grant_d;
   logic        load_q;
   logic [2:0]  trim_q;
   logic [1:0]  alo_q;
   logic [31:0] aligned;
   logic        fault;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;

   assign STALL = (IF_REQ & ~IF_VALID) | (D_REQ & ~D_VALID);

   always_comb begin
      fault      = data_fault(D_WR, D_TRIM, D_ADDR[1:0]);
      be_next    = 4'b1111;
      wdata_next = D_WDATA;
      case (D_WR)
         MM_WR_B: begin
            be_next    = 4'b0001 << D_ADDR[1:0];
            wdata_next = {4{D_WDATA[7:0]}};
         end
         MM_WR_HW: begin
            be_next    = D_ADDR[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{D_WDATA[15:0]}};
         end
         MM_WR_N:  wdata_next = 32'd0;
         default:  ;
      endcase
   end

   load_align u_align (
      .word    (MEM_RDATA),
      .addr_lo (alo_q),
      .funct3  (trim_q),
      .result  (aligned)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= MPC_IDLE;
         tmo_cnt   <= 8'd0;
         grant_d   <= 1'b0;
         load_q    <= 1'b0;
         trim_q    <= 3'd0;
         alo_q     <= 2'd0;
         IF_RDATA  <= 32'd0;
         IF_VALID  <= 1'b0;
         D_RDATA   <= 32'd0;
         D_VALID   <= 1'b0;
         ERR       <= 1'b0;
         MEM_REQ   <= 1'b0;
         MEM_WE    <= 1'b0;
         MEM_BE    <= 4'd0;
         MEM_ADDR  <= 32'd0;
         MEM_WDATA <= 32'd0;
      end else begin
         case (state)
            MPC_IDLE: begin
               // Data wins the port so the pipeline can retire the memory op first.
               if (D_REQ) begin
                  grant_d <= 1'b1;
                  load_q  <= (D_WR == MM_WR_N);
                  trim_q  <= D_TRIM;
                  alo_q   <= D_ADDR[1:0];
                  if (fault) begin
                     state   <= MPC_RESP;
                     D_VALID <= 1'b1;
                     ERR     <= 1'b1;
                  end else begin
                     state     <= MPC_BUSY;
                     MEM_REQ   <= 1'b1;
                     MEM_WE    <= (D_WR != MM_WR_N);
                     MEM_BE    <= be_next;
                     MEM_ADDR  <= D_ADDR & 32'hFFFF_FFFC;
                     MEM_WDATA <= wdata_next;
                  end
               end else if (IF_REQ) begin
                  grant_d   <= 1'b0;
                  state     <= MPC_BUSY;
                  MEM_REQ   <= 1'b1;
                  MEM_WE    <= 1'b0;
                  MEM_BE    <= 4'b1111;
                  MEM_ADDR  <= IF_ADDR & 32'hFFFF_FFFC;
                  MEM_WDATA <= 32'd0;
               end
            end
            MPC_BUSY: begin
               if (MEM_ACK || tmo_cnt == TMO_LAST) begin
                  state     <= MPC_RESP;
                  tmo_cnt   <= 8'd0;
                  MEM_REQ   <= 1'b0;
                  MEM_WE    <= 1'b0;
                  MEM_BE    <= 4'd0;
                  MEM_ADDR  <= 32'd0;
                  MEM_WDATA <= 32'd0;
                  ERR       <= ~MEM_ACK;
                  if (grant_d) begin
                     D_VALID <= 1'b1;
                     D_RDATA <= (MEM_ACK && load_q) ? aligned : 32'd0;
                  end else begin
                     IF_VALID <= 1'b1;
                     IF_RDATA <= MEM_ACK ? MEM_RDATA : 32'd0;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            MPC_RESP: begin
               state    <= MPC_IDLE;
               IF_VALID <= 1'b0;
               D_VALID  <= 1'b0;
               ERR      <= 1'b0;
               IF_RDATA <= 32'd0;
               D_RDATA  <= 32'd0;
            end
            default: state <= MPC_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_ctl.sv
// tb/tb_mem_port_ctl.sv - randomized self-checking bench for mem_port_ctl
module tb_mem_port_ctl;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        IF_REQ = 1'b0;
   logic [31:0] IF_ADDR = 32'd0;
   logic [31:0] IF_RDATA;
   logic        IF_VALID;
   logic        D_REQ = 1'b0;
   logic [1:0]  D_WR = 2'd0;
   logic [2:0]  D_TRIM = 3'd0;
   logic [31:0] D_ADDR = 32'd0;
   logic [31:0] D_WDATA = 32'd0;
   logic [31:0] D_RDATA;
   logic        D_VALID;
   logic        ERR;
   logic        STALL;
   logic        MEM_REQ;
   logic        MEM_WE;
   logic [3:0]  MEM_BE;
   logic [31:0] MEM_ADDR;
   logic [31:0] MEM_WDATA;
   logic        MEM_ACK = 1'b0;
   logic [31:0] MEM_RDATA = 32'd0;

   int vectors = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   mem_port_ctl #(.TIMEOUT(15)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_VALID(IF_VALID),
      .D_REQ(D_REQ), .D_WR(D_WR), .D_TRIM(D_TRIM), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_RDATA(D_RDATA), .D_VALID(D_VALID), .ERR(ERR), .STALL(STALL),
      .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
      .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
   );

   function automatic int ref_size(input bit ld, input logic [1:0] wr, input logic [2:0] trim);
      if (ld) return (trim[1:0] == 2'd0) ? 1 : (trim[1:0] == 2'd1) ? 2 : 4;
      return (wr == 2'd1) ? 1 : (wr == 2'd2) ? 2 : 4;
   endfunction

   function automatic bit ref_fault(input bit ld, input logic [1:0] wr, input logic [2:0] trim,
                                    input logic [31:0] addr);
      int n;
      n = ref_size(ld, wr, trim);
      if (ld && (trim == 3'd3 || trim == 3'd6 || trim == 3'd7)) return 1'b1;
      return (addr % n) != 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] a,
                                            input logic [2:0] trim);
      int n;
      logic [31:0] v;
      n = ref_size(1'b1, 2'd0, trim);
      v = word >> (8 * a);
      if (n == 1) begin
         v = v & 32'hFF;
         if (!trim[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (n == 2) begin
         v = v & 32'hFFFF;
         if (!trim[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input int n);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   task automatic run_access(input bit fetch, input logic [1:0] wr, input logic [2:0] trim,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] word, input int delay, input string tag);
      bit ld;
      bit st;
      bit exp_err;
      int n;
      logic [3:0] exp_be;
      logic [31:0] exp_rd;
      logic [31:0] got_rd;
      ld = !fetch && (wr == 2'd0);
      st = !fetch && !ld;
      n = ref_size(ld, wr, trim);
      exp_err = !fetch && ref_fault(ld, wr, trim, addr);
      exp_be = st ? 4'(((1 << n) - 1) << (addr % 4)) : 4'hF;
      exp_rd = exp_err ? 32'd0 : fetch ? word : ld ? ref_load(word, addr[1:0], trim) : 32'd0;
      @(posedge CLK); #1;
      if (fetch) begin
         IF_REQ = 1'b1; IF_ADDR = addr;
      end else begin
         D_REQ = 1'b1; D_WR = wr; D_TRIM = trim; D_ADDR = addr; D_WDATA = wd;
      end
      @(posedge CLK); #1;
      if (!exp_err) begin
         vectors++;
         if ({MEM_REQ, MEM_WE, MEM_BE, STALL} !== {1'b1, st, exp_be, 1'b1}) begin
            errors++;
            $display("FAIL %s req/we/be/stall got %b%b %b %b want 1%b %b 1", tag,
                     MEM_REQ, MEM_WE, MEM_BE, STALL, st, exp_be);
         end
         vectors++;
         if (MEM_ADDR !== (addr & 32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL %s mem_addr got %h want %h", tag, MEM_ADDR, addr & 32'hFFFF_FFFC);
         end
         if (st) begin
            vectors++;
            if (MEM_WDATA !== ref_wdata(wd, n)) begin
               errors++;
               $display("FAIL %s mem_wdata got %h want %h", tag, MEM_WDATA, ref_wdata(wd, n));
            end
         end
         for (int i = 0; i < delay; i++) begin
            @(posedge CLK); #1;
            vectors++;
            if ({MEM_REQ, IF_VALID, D_VALID} !== 3'b100) begin
               errors++;
               $display("FAIL %s hold req/ifv/dv got %b%b%b want 100", tag,
                        MEM_REQ, IF_VALID, D_VALID);
            end
         end
         MEM_ACK = 1'b1; MEM_RDATA = word;
         @(posedge CLK); #1;
         MEM_ACK = 1'b0; MEM_RDATA = $urandom;
      end
      vectors++;
      if ({IF_VALID, D_VALID, ERR, MEM_REQ} !== {fetch, !fetch, exp_err, 1'b0}) begin
         errors++;
         $display("FAIL %s resp ifv/dv/err/req got %b%b%b%b want %b%b%b0", tag,
                  IF_VALID, D_VALID, ERR, MEM_REQ, fetch, !fetch, exp_err);
      end
      got_rd = fetch ? IF_RDATA : D_RDATA;
      vectors++;
      if (got_rd !== exp_rd) begin
         errors++;
         $display("FAIL %s rdata got %h want %h", tag, got_rd, exp_rd);
      end
      IF_REQ = 1'b0; D_REQ = 1'b0;
      @(posedge CLK); #1;
      vectors++;
      if ({IF_VALID, D_VALID, ERR, MEM_REQ} !== 4'b0000) begin
         errors++;
         $display("FAIL %s idle ifv/dv/err/req got %b%b%b%b want 0000", tag,
                  IF_VALID, D_VALID, ERR, MEM_REQ);
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      vectors++;
      if ({IF_RDATA, IF_VALID, D_RDATA, D_VALID, ERR, STALL, MEM_REQ, MEM_WE, MEM_BE,
           MEM_ADDR, MEM_WDATA} !== '0) begin
         errors++;
         $display("FAIL reset outputs got req=%b ifv=%b dv=%b err=%b addr=%h want all 0",
                  MEM_REQ, IF_VALID, D_VALID, ERR, MEM_ADDR);
      end
      RST_N = 1'b1;
   endtask

   task automatic test_fetch();
      run_access(1'b1, 2'd0, 3'd0, 32'h10, 32'd0, 32'h0050_0093, 0, "fetch");
      run_access(1'b1, 2'd0, 3'd0, 32'h47, 32'd0, 32'hDEAD_BEEF, 2, "fetch_unaligned");
   endtask

   task automatic test_store();
      run_access(1'b0, 2'd1, 3'd0, 32'h23, 32'h0000_00AB, 32'd0, 0, "store_b");
      run_access(1'b0, 2'd2, 3'd0, 32'h22, 32'h0000_1234, 32'd0, 1, "store_hw");
      run_access(1'b0, 2'd3, 3'd0, 32'h24, 32'hCAFE_F00D, 32'd0, 2, "store_w");
   endtask

   task automatic test_load();
      run_access(1'b0, 2'd0, 3'b000, 32'h21, 32'd0, 32'h0000_F000, 0, "lb");
      run_access(1'b0, 2'd0, 3'b100, 32'h21, 32'd0, 32'h0000_F000, 0, "lbu");
      run_access(1'b0, 2'd0, 3'b001, 32'h22, 32'd0, 32'h8000_0000, 1, "lh");
      run_access(1'b0, 2'd0, 3'b101, 32'h22, 32'd0, 32'h8000_0000, 0, "lhu");
      run_access(1'b0, 2'd0, 3'b010, 32'h20, 32'd0, 32'h1234_5678, 3, "lw");
   endtask

   task automatic test_misalign();
      run_access(1'b0, 2'd0, 3'b010, 32'h22, 32'd0, 32'd0, 0, "lw_misalign");
      run_access(1'b0, 2'd0, 3'b101, 32'h23, 32'd0, 32'd0, 0, "lhu_misalign");
      run_access(1'b0, 2'd2, 3'd0, 32'h21, 32'h55, 32'd0, 0, "sh_misalign");
      run_access(1'b0, 2'd3, 3'd0, 32'h26, 32'h55, 32'd0, 0, "sw_misalign");
      run_access(1'b0, 2'd0, 3'b011, 32'h20, 32'd0, 32'd0, 0, "bad_funct3");
   endtask

   task automatic test_arbitration();
      logic [31:0] dword;
      dword = $urandom;
      @(posedge CLK); #1;
      IF_REQ = 1'b1; IF_ADDR = 32'h30;
      D_REQ = 1'b1; D_WR = 2'd0; D_TRIM = 3'b010; D_ADDR = 32'h20;
      @(posedge CLK); #1;
      vectors++;
      if ({MEM_REQ, MEM_WE, MEM_ADDR, STALL} !== {1'b1, 1'b0, 32'h20, 1'b1}) begin
         errors++;
         $display("FAIL arb data_first req/we/addr/stall got %b%b %h %b want 10 00000020 1",
                  MEM_REQ, MEM_WE, MEM_ADDR, STALL);
      end
      MEM_ACK = 1'b1; MEM_RDATA = dword;
      @(posedge CLK); #1;
      MEM_ACK = 1'b0;
      vectors++;
      if ({D_VALID, IF_VALID, STALL, D_RDATA} !== {1'b1, 1'b0, 1'b1, dword}) begin
         errors++;
         $display("FAIL arb data_resp dv/ifv/stall/rdata got %b%b%b %h want 101 %h",
                  D_VALID, IF_VALID, STALL, D_RDATA, dword);
      end
      D_REQ = 1'b0;
      @(posedge CLK); #1;
      vectors++;
      if ({MEM_REQ, STALL} !== 2'b01) begin
         errors++;
         $display("FAIL arb gap req/stall got %b%b want 01", MEM_REQ, STALL);
      end
      @(posedge CLK); #1;
      vectors++;
      if ({MEM_REQ, MEM_ADDR, STALL} !== {1'b1, 32'h30, 1'b1}) begin
         errors++;
         $display("FAIL arb fetch_next req/addr/stall got %b %h %b want 1 00000030 1",
                  MEM_REQ, MEM_ADDR, STALL);
      end
      MEM_ACK = 1'b1; MEM_RDATA = 32'h0000_0013;
      @(posedge CLK); #1;
      MEM_ACK = 1'b0;
      vectors++;
      if ({IF_VALID, D_VALID, ERR, IF_RDATA} !== {3'b100, 32'h13}) begin
         errors++;
         $display("FAIL arb fetch_resp ifv/dv/err/rdata got %b%b%b %h want 100 00000013",
                  IF_VALID, D_VALID, ERR, IF_RDATA);
      end
      IF_REQ = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_timeout();
      int held;
      held = 0;
      @(posedge CLK); #1;
      D_REQ = 1'b1; D_WR = 2'd0; D_TRIM = 3'b010; D_ADDR = 32'h40;
      for (int i = 0; i < 15; i++) begin
         @(posedge CLK); #1;
         if (MEM_REQ === 1'b1 && D_VALID === 1'b0) held++;
      end
      vectors++;
      if (held != 15) begin
         errors++;
         $display("FAIL timeout busy_cycles got %0d want 15", held);
      end
      @(posedge CLK); #1;
      vectors++;
      if ({MEM_REQ, D_VALID, ERR, D_RDATA} !== {3'b011, 32'd0}) begin
         errors++;
         $display("FAIL timeout resp req/dv/err/rdata got %b%b%b %h want 011 00000000",
                  MEM_REQ, D_VALID, ERR, D_RDATA);
      end
      D_REQ = 1'b0;
      @(posedge CLK); #1;
      vectors++;
      if ({D_VALID, ERR} !== 2'b00) begin
         errors++;
         $display("FAIL timeout after dv/err got %b%b want 00", D_VALID, ERR);
      end
   endtask

   task automatic test_reset_mid_busy();
      int spurious;
      spurious = 0;
      @(posedge CLK); #1;
      IF_REQ = 1'b1; IF_ADDR = 32'h50;
      repeat (2) @(posedge CLK);
      #1;
      vectors++;
      if (MEM_REQ !== 1'b1) begin
         errors++;
         $display("FAIL rst_busy pre req got %b want 1", MEM_REQ);
      end
      RST_N = 1'b0; IF_REQ = 1'b0; MEM_ACK = 1'b1; MEM_RDATA = 32'h1111_2222;
      @(posedge CLK); #1;
      vectors++;
      if ({IF_RDATA, IF_VALID, D_RDATA, D_VALID, ERR, STALL, MEM_REQ, MEM_WE, MEM_BE,
           MEM_ADDR, MEM_WDATA} !== '0) begin
         errors++;
         $display("FAIL rst_busy outputs got req=%b ifv=%b err=%b addr=%h want all 0",
                  MEM_REQ, IF_VALID, ERR, MEM_ADDR);
      end
      RST_N = 1'b1; MEM_ACK = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
         if (IF_VALID !== 1'b0 || D_VALID !== 1'b0 || MEM_REQ !== 1'b0) spurious++;
      end
      vectors++;
      if (spurious != 0) begin
         errors++;
         $display("FAIL rst_busy spurious_cycles got %0d want 0", spurious);
      end
   endtask

   task automatic test_random();
      bit fetch;
      for (int i = 0; i < 40; i++) begin
         fetch = ($urandom_range(0, 2) == 0);
         run_access(fetch, 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_load();
      test_misalign();
      test_arbitration();
      test_timeout();
      test_reset_mid_busy();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
